// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode indices, constant table, field positions and FSM states for the ALU issue controller
package alu_pkg;

    // ALU operation indices (alu_instr[4:1])
    localparam logic [3:0] K_ADD  = 4'd0;
    localparam logic [3:0] K_ADDC = 4'd1;
    localparam logic [3:0] K_SUB  = 4'd2;
    localparam logic [3:0] K_SUBC = 4'd3;
    localparam logic [3:0] K_DADD = 4'd4;
    localparam logic [3:0] K_CMP  = 4'd5;
    localparam logic [3:0] K_XOR  = 4'd6;
    localparam logic [3:0] K_AND  = 4'd7;
    localparam logic [3:0] K_OR   = 4'd8;
    localparam logic [3:0] K_BIT  = 4'd9;
    localparam logic [3:0] K_BIC  = 4'd10;
    localparam logic [3:0] K_BIS  = 4'd11;
    localparam logic [3:0] K_SRA  = 4'd12;
    localparam logic [3:0] K_RRC  = 4'd13;

    // Opcode byte ranges
    localparam logic [7:0] OPC_2OP_LO = 8'h40;
    localparam logic [7:0] OPC_2OP_HI = 8'h4B;
    localparam logic [7:0] OPC_UNARY  = 8'h4D;

    // Instruction field positions
    localparam int RC_BIT  = 7;
    localparam int B_BIT   = 6;
    localparam int SRC_LSB = 3;
    localparam int DST_LSB = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_OPER,
        S_EXEC,
        S_CAPT,
        S_WB,
        S_ERR
    } state_t;

    typedef struct packed {
        logic       legal;
        logic [3:0] k;
        logic       b;
        logic       rc;
        logic       unary;
        logic [2:0] src;
        logic [2:0] dst;
        logic       wb_en;
    } dec_t;

    // CON0..CON7 constant table selected by the SRC/CON field when R/C=1
    function automatic logic [15:0] con_value(input logic [2:0] idx);
        logic [15:0] v;
        case (idx)
            3'd0:    v = 16'h0000;
            3'd1:    v = 16'h0001;
            3'd2:    v = 16'h0002;
            3'd3:    v = 16'h0004;
            3'd4:    v = 16'h0008;
            3'd5:    v = 16'h0010;
            3'd6:    v = 16'h0020;
            default: v = 16'hFFFF;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// rtl/alu_issue_ctrl_if.sv - ALU issue bus: operands/opcode/PSW/strobe out, result/PSW back
// master: issue controller (drives operands, opcode, strobe); slave: the ALU.
interface alu_issue_ctrl_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] alu_op1;
    logic [DATA_W-1:0] alu_op2;
    logic [5:0]        alu_instr;
    logic [DATA_W-1:0] alu_psw_i;
    logic              alu_e;
    logic              alu_instr_opt;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] alu_psw_o;

    modport master (
        output alu_op1, alu_op2, alu_instr, alu_psw_i, alu_e, alu_instr_opt,
        input  alu_result, alu_psw_o
    );

    modport slave (
        input  alu_op1, alu_op2, alu_instr, alu_psw_i, alu_e, alu_instr_opt,
        output alu_result, alu_psw_o
    );
endinterface

// File: rtl/alu_issue_decode.sv
// rtl/alu_issue_decode.sv - combinational decode of an XM-23 arithmetic/logic word
// Ports: instr_word in (16), dec out (legal, k, B, R/C, unary, src, dst, wb_en).
module alu_issue_decode
    import alu_pkg::*;
(
    input  logic [15:0] instr_word,
    output dec_t        dec
);

    logic [7:0] opc;

    always_comb begin
        opc       = instr_word[15:8];
        dec       = '0;
        dec.b     = instr_word[B_BIT];
        dec.rc    = instr_word[RC_BIT];
        dec.src   = instr_word[SRC_LSB +: 3];
        dec.dst   = instr_word[DST_LSB +: 3];
        if (opc >= OPC_2OP_LO && opc <= OPC_2OP_HI) begin
            dec.legal = 1'b1;
            dec.k     = opc[3:0];
        end else if (opc == OPC_UNARY && !instr_word[RC_BIT]
                     && instr_word[SRC_LSB+1 +: 2] == 2'b00) begin
            // SRC field bit 3 selects SRA (0) or RRC (1)
            dec.legal = 1'b1;
            dec.unary = 1'b1;
            dec.k     = instr_word[SRC_LSB] ? K_RRC : K_SRA;
        end
        // CMP and BIT only update the PSW
        dec.wb_en = dec.legal && (dec.k != K_CMP) && (dec.k != K_BIT);
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - issues one arithmetic/logic instruction to the ALU and writes back result and PSW
// Ports: clk/rst; start_valid/start_ready/instr_word accept handshake; psw_in current PSW;
// rf_raddr_*/rf_rdata_* register reads; alu_bus ALU issue bus (master);
// rf_we/rf_waddr/rf_wdata and psw_we/psw_wdata write-back; done/illegal completion.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [15:0]       instr_word,
    input  logic [DATA_W-1:0] psw_in,
    output logic [REG_AW-1:0] rf_raddr_src,
    output logic [REG_AW-1:0] rf_raddr_dst,
    input  logic [DATA_W-1:0] rf_rdata_src,
    input  logic [DATA_W-1:0] rf_rdata_dst,
    alu_issue_ctrl_if.master  alu_bus,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              psw_we,
    output logic [DATA_W-1:0] psw_wdata,
    output logic              done,
    output logic              illegal
);

    state_t            state_q, state_d;
    logic [15:0]       instr_q, instr_d;
    logic [DATA_W-1:0] op1_q, op1_d;
    logic [DATA_W-1:0] op2_q, op2_d;
    logic [5:0]        opc_q, opc_d;
    logic [DATA_W-1:0] pswi_q, pswi_d;
    logic              opt_q, opt_d;
    logic              e_q, e_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic [DATA_W-1:0] pswr_q, pswr_d;
    dec_t              dec;

    // Decode always works on the held word, so fields stay stable for the whole operation
    alu_issue_decode u_decode (
        .instr_word (instr_q),
        .dec        (dec)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            instr_q <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            opc_q   <= '0;
            pswi_q  <= '0;
            opt_q   <= 1'b0;
            e_q     <= 1'b0;
            res_q   <= '0;
            pswr_q  <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            opc_q   <= opc_d;
            pswi_q  <= pswi_d;
            opt_q   <= opt_d;
            e_q     <= e_d;
            res_q   <= res_d;
            pswr_q  <= pswr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        opc_d   = opc_q;
        pswi_d  = pswi_q;
        opt_d   = opt_q;
        e_d     = 1'b0;
        res_d   = res_q;
        pswr_d  = pswr_q;
        case (state_q)
            S_IDLE: begin
                if (start_valid) begin
                    instr_d = instr_word;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = dec.legal ? S_OPER : S_ERR;
            S_OPER: begin
                op1_d = rf_rdata_dst;
                if (dec.unary)
                    op2_d = '0;
                else if (dec.rc)
                    op2_d = con_value(dec.src);
                else
                    op2_d = rf_rdata_src;
                opc_d   = {1'b0, dec.k, dec.b};
                pswi_d  = psw_in;
                opt_d   = 1'b1;
                // Strobe flop is set here so alu_e is high for exactly the EXEC cycle
                e_d     = 1'b1;
                state_d = S_EXEC;
            end
            S_EXEC: state_d = S_CAPT;
            S_CAPT: begin
                res_d   = alu_bus.alu_result;
                pswr_d  = alu_bus.alu_psw_o;
                state_d = S_WB;
            end
            S_WB:    state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign start_ready   = (state_q == S_IDLE);
    assign rf_raddr_src  = dec.src;
    assign rf_raddr_dst  = dec.dst;

    assign alu_bus.alu_op1       = op1_q;
    assign alu_bus.alu_op2       = op2_q;
    assign alu_bus.alu_instr     = opc_q;
    assign alu_bus.alu_psw_i     = pswi_q;
    assign alu_bus.alu_e         = e_q;
    assign alu_bus.alu_instr_opt = opt_q;

    assign rf_we     = (state_q == S_WB) && dec.wb_en;
    assign rf_waddr  = dec.dst;
    assign rf_wdata  = res_q;
    assign psw_we    = (state_q == S_WB);
    assign psw_wdata = pswr_q;
    assign done      = (state_q == S_WB) || (state_q == S_ERR);
    assign illegal   = (state_q == S_ERR);

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - directed self-checking bench for alu_issue_ctrl
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_valid;
    logic        start_ready;
    logic [15:0] instr_word;
    logic [15:0] psw_in;
    logic [2:0]  rf_raddr_src, rf_raddr_dst;
    logic [15:0] rf_rdata_src, rf_rdata_dst;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic        psw_we;
    logic [15:0] psw_wdata;
    logic        done;
    logic        illegal;

    alu_issue_ctrl_if #(.DATA_W(16)) alu_bus ();

    alu_issue_ctrl #(.DATA_W(16), .REG_AW(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .instr_word   (instr_word),
        .psw_in       (psw_in),
        .rf_raddr_src (rf_raddr_src),
        .rf_raddr_dst (rf_raddr_dst),
        .rf_rdata_src (rf_rdata_src),
        .rf_rdata_dst (rf_rdata_dst),
        .alu_bus      (alu_bus),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .psw_we       (psw_we),
        .psw_wdata    (psw_wdata),
        .done         (done),
        .illegal      (illegal)
    );

    always #5 clk = ~clk;

    logic [15:0] rf [8];
    assign rf_rdata_src = rf[rf_raddr_src];
    assign rf_rdata_dst = rf[rf_raddr_dst];

    // Minimal ALU: only the operations exercised here; PSW bit0 is carry
    logic [16:0] sum;
    always_comb begin
        sum = {1'b0, alu_bus.alu_op1} + {1'b0, alu_bus.alu_op2};
        alu_bus.alu_result = 16'h0000;
        alu_bus.alu_psw_o  = alu_bus.alu_psw_i;
        case (alu_bus.alu_instr[4:1])
            4'd0: begin
                alu_bus.alu_result = sum[15:0];
                alu_bus.alu_psw_o  = {alu_bus.alu_psw_i[15:1], sum[16]};
            end
            4'd5: begin
                alu_bus.alu_result = alu_bus.alu_op1 - alu_bus.alu_op2;
                alu_bus.alu_psw_o  = {alu_bus.alu_psw_i[15:1], 1'b1};
            end
            4'd12: begin
                alu_bus.alu_result = {alu_bus.alu_op1[15], alu_bus.alu_op1[15:1]};
                alu_bus.alu_psw_o  = {alu_bus.alu_psw_i[15:1], alu_bus.alu_op1[0]};
            end
            4'd13: begin
                alu_bus.alu_result = {alu_bus.alu_psw_i[0], alu_bus.alu_op1[15:1]};
                alu_bus.alu_psw_o  = {alu_bus.alu_psw_i[15:1], alu_bus.alu_op1[0]};
            end
            default: ;
        endcase
    end

    int          e_cnt = 0, rfwe_cnt = 0, pswwe_cnt = 0;
    logic [15:0] e_op1, e_op2;
    logic [5:0]  e_instr;
    logic        e_opt;

    always @(negedge clk) begin
        if (alu_bus.alu_e) begin
            e_cnt   = e_cnt + 1;
            e_op1   = alu_bus.alu_op1;
            e_op2   = alu_bus.alu_op2;
            e_instr = alu_bus.alu_instr;
            e_opt   = alu_bus.alu_instr_opt;
        end
        if (rf_we)  rfwe_cnt  = rfwe_cnt + 1;
        if (psw_we) pswwe_cnt = pswwe_cnt + 1;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    int          s_lat;
    logic        s_rf_we, s_psw_we, s_illegal;
    logic [2:0]  s_waddr;
    logic [15:0] s_wdata, s_psw_wdata;

    // Issues one word from IDLE and snapshots outputs in the done cycle
    task automatic issue(input logic [15:0] w);
        int lat;
        @(negedge clk);
        check_eq("ready_idle", start_ready, 1);
        start_valid = 1'b1;
        instr_word  = w;
        @(negedge clk);
        start_valid = 1'b0;
        lat = 1;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        s_lat       = lat;
        s_rf_we     = rf_we;
        s_waddr     = rf_waddr;
        s_wdata     = rf_wdata;
        s_psw_we    = psw_we;
        s_psw_wdata = psw_wdata;
        s_illegal   = illegal;
        @(negedge clk);
    endtask

    int e0, w0, p0, d1, d2, nready;

    initial begin
        start_valid = 1'b0;
        instr_word  = 16'h0000;
        psw_in      = 16'h0000;
        for (int i = 0; i < 8; i++) rf[i] = 16'h0000;

        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst_ready", start_ready, 1);
        check_eq("rst_done", done, 0);
        check_eq("rst_alu_e", alu_bus.alu_e, 0);
        check_eq("rst_we", {rf_we, psw_we, illegal}, 0);
        check_eq("rst_op1", alu_bus.alu_op1, 0);
        rst = 1'b0;

        // ADD R2,R1
        rf[1] = 16'h0005; rf[2] = 16'h0003; psw_in = 16'h0000;
        e0 = e_cnt;
        issue(16'h4011);
        check_eq("add_lat", s_lat, 5);
        check_eq("add_epulse", e_cnt - e0, 1);
        check_eq("add_instr", e_instr, 6'b000000);
        check_eq("add_op1", e_op1, 16'h0005);
        check_eq("add_op2", e_op2, 16'h0003);
        check_eq("add_opt", e_opt, 1);
        check_eq("add_rfwe", s_rf_we, 1);
        check_eq("add_waddr", s_waddr, 1);
        check_eq("add_wdata", s_wdata, 16'h0008);
        check_eq("add_pswwe", s_psw_we, 1);
        check_eq("add_pswd", s_psw_wdata, 16'h0000);
        check_eq("add_ill", s_illegal, 0);

        // CMP #2,R3: PSW only
        rf[3] = 16'h1234; psw_in = 16'h0010;
        w0 = rfwe_cnt;
        issue(16'h4593);
        check_eq("cmp_lat", s_lat, 5);
        check_eq("cmp_instr", e_instr, 6'b001010);
        check_eq("cmp_op1", e_op1, 16'h1234);
        check_eq("cmp_op2", e_op2, 16'h0002);
        check_eq("cmp_rfwe", s_rf_we, 0);
        check_eq("cmp_rfwe_cnt", rfwe_cnt - w0, 0);
        check_eq("cmp_pswwe", s_psw_we, 1);
        check_eq("cmp_pswd", s_psw_wdata, 16'h0011);

        // SRA R4: carry out of bit0 clears PSW carry
        rf[4] = 16'h8002; psw_in = 16'h0001;
        issue(16'h4D04);
        check_eq("sra_instr", e_instr, 6'b011000);
        check_eq("sra_op2", e_op2, 16'h0000);
        check_eq("sra_waddr", s_waddr, 4);
        check_eq("sra_wdata", s_wdata, 16'hC001);
        check_eq("sra_pswd", s_psw_wdata, 16'h0000);

        // RRC R4 (SRC field bit3 set)
        psw_in = 16'h0000;
        issue(16'h4D0C);
        check_eq("rrc_instr", e_instr, 6'b011010);
        check_eq("rrc_wdata", s_wdata, 16'h4001);

        // ADD.B #-1 (CON7),R1: byte flag passed, upper byte not masked
        rf[1] = 16'h1205;
        issue(16'h40F9);
        check_eq("addb_instr", e_instr, 6'b000001);
        check_eq("addb_op2", e_op2, 16'hFFFF);
        check_eq("addb_wdata", s_wdata, 16'h1204);
        check_eq("addb_pswd", s_psw_wdata, 16'h0001);

        // Illegal words
        e0 = e_cnt; w0 = rfwe_cnt; p0 = pswwe_cnt;
        issue(16'h60FF);
        check_eq("ill_lat", s_lat, 2);
        check_eq("ill_flag", s_illegal, 1);
        check_eq("ill_writes", {s_rf_we, s_psw_we}, 0);
        issue(16'h4D10);
        check_eq("ill_unary", {s_illegal, 5'(s_lat)}, {1'b1, 5'd2});
        issue(16'h4C00);
        check_eq("ill_4c", {s_illegal, 5'(s_lat)}, {1'b1, 5'd2});
        check_eq("ill_no_e", e_cnt - e0, 0);
        check_eq("ill_no_wr", (rfwe_cnt - w0) + (pswwe_cnt - p0), 0);

        // Back-to-back with start_valid held high
        rf[1] = 16'h0005;
        @(negedge clk);
        start_valid = 1'b1; instr_word = 16'h4011;
        e0 = e_cnt; d1 = -1; d2 = -1; nready = 0;
        for (int i = 0; i < 12; i++) begin
            if (start_ready) nready++;
            if (done) begin
                if (d1 < 0) d1 = i;
                else        d2 = i;
            end
            @(negedge clk);
        end
        start_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("b2b_done1", d1, 5);
        check_eq("b2b_done2", d2, 11);
        check_eq("b2b_ready", nready, 2);
        check_eq("b2b_epulse", e_cnt - e0, 2);

        // Reset while ADD is in EXEC
        @(negedge clk);
        start_valid = 1'b1; instr_word = 16'h4011;
        @(negedge clk);
        start_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("abort_exec_e", alu_bus.alu_e, 1);
        w0 = rfwe_cnt; p0 = pswwe_cnt;
        rst = 1'b1;
        #1;
        check_eq("abort_async_e", alu_bus.alu_e, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("abort_ready", start_ready, 1);
        check_eq("abort_outs", {done, illegal, rf_we, psw_we, alu_bus.alu_e}, 0);
        check_eq("abort_op1", alu_bus.alu_op1, 0);
        check_eq("abort_wdata", rf_wdata, 0);
        repeat (8) @(negedge clk);
        check_eq("abort_no_wr", (rfwe_cnt - w0) + (pswwe_cnt - p0), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
